// File: rtl/afu_rfifo_sync.sv
// Single-clock FIFO for AFU read-response buffering with fill level, almost-full and sticky errors.
// Define AFU_RFIFO_SHOWAHEAD_EN for show-ahead output (head entry always on q); default is registered read.
module afu_rfifo_sync #(
    parameter int WIDTH     = 521,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AWIDTH    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic [WIDTH-1:0]  data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [WIDTH-1:0]  q,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [AWIDTH:0]   usedw,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AWIDTH:0]   DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_C    = (AWIDTH+1)'(AF_THRESH);
    localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_usedw;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AWIDTH:0]   w_usedw_nxt;

    // Handshake: wrreq/rdreq are single-cycle request strobes with no ready return path.
    // A write is taken iff wrreq && !full, a read iff rdreq && !empty (flags as seen before the
    // edge); refused requests are dropped and recorded in the sticky overflow/underflow flags.
    assign w_wr_acc = wrreq && !r_full;
    assign w_rd_acc = rdreq && !r_empty;

    always_comb begin
        w_usedw_nxt = r_usedw;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_usedw_nxt = r_usedw + CNT_ONE;
            2'b01:   w_usedw_nxt = r_usedw - CNT_ONE;
            default: w_usedw_nxt = r_usedw;
        endcase
    end

    // Storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (!sclr && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_usedw       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_usedw       <= w_usedw_nxt;
            r_empty       <= (w_usedw_nxt == '0);
            r_full        <= (w_usedw_nxt == DEPTH_C);
            r_almost_full <= (w_usedw_nxt >= AF_C);
            if (wrreq && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rdreq && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef AFU_RFIFO_SHOWAHEAD_EN
    // Head entry is presented combinationally; rdreq simply pops it.
    assign q = r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_q <= '0;
        end else if (w_rd_acc) begin
            r_q <= r_mem[r_rd_ptr];
        end
    end

    assign q = r_q;
`endif

    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign usedw       = r_usedw;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_afu_rfifo_sync.sv
// Directed bench for afu_rfifo_sync (DEPTH=4, AF_THRESH=3): vector table plus a wrap-around scoreboard run.
module tb_afu_rfifo_sync;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int AF  = 3;
  localparam int AW  = $clog2(D);

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          sclr  = 1'b0;
  logic [W-1:0]  data  = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [W-1:0]  q;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   usedw;
  logic          overflow;
  logic          underflow;

  always #5 clock = ~clock;

  afu_rfifo_sync #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF)
  ) dut (
    .clock       (clock),
    .sclr        (sclr),
    .data        (data),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .q           (q),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .usedw       (usedw),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         sclr;
    logic         wr;
    logic         rd;
    logic [W-1:0] d;
    logic [W-1:0] e_q;
    logic [AW:0]  e_usedw;
    logic         e_empty;
    logic         e_full;
    logic         e_af;
    logic         e_ovf;
    logic         e_udf;
  } vec_t;

  vec_t vecs[25];
  int   n_vecs = 0;

  task automatic add(input logic s, input logic wr, input logic rd, input logic [W-1:0] d,
                     input logic [W-1:0] eq, input int eu, input logic ee, input logic ef,
                     input logic ea, input logic eo, input logic ed);
    vecs[n_vecs] = '{s, wr, rd, d, eq, (AW+1)'(eu), ee, ef, ea, eo, ed};
    n_vecs++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic wr, input logic rd, input logic [W-1:0] d);
    sclr  = s;
    wrreq = wr;
    rdreq = rd;
    data  = d;
    @(posedge clock);
    #1;
    sclr  = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(vecs[i].sclr, vecs[i].wr, vecs[i].rd, vecs[i].d);
`ifndef AFU_RFIFO_SHOWAHEAD_EN
      check($sformatf("v%0d q", i), 32'(q), 32'(vecs[i].e_q));
`endif
      check($sformatf("v%0d usedw", i), 32'(usedw), 32'(vecs[i].e_usedw));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].e_udf));
    end
  endtask

  int mid;

  initial begin
    //    sclr wr rd data    q     u  e  f  af ovf udf
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0);  // reset
    add(0, 1, 0, 16'h000A, 16'h0000, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h000B, 16'h0000, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h000C, 16'h0000, 3, 0, 0, 1, 0, 0);  // almost_full at 3
    add(0, 1, 0, 16'h000D, 16'h0000, 4, 0, 1, 1, 0, 0);  // full
    add(0, 1, 0, 16'h000E, 16'h0000, 4, 0, 1, 1, 1, 0);  // write while full rejected
    add(0, 0, 1, 16'h0000, 16'h000A, 3, 0, 0, 1, 1, 0);
    add(0, 0, 1, 16'h0000, 16'h000B, 2, 0, 0, 0, 1, 0);
    add(0, 0, 1, 16'h0000, 16'h000C, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 16'h0000, 16'h000D, 0, 1, 0, 0, 1, 0);  // 0xE never stored
    add(0, 0, 1, 16'h0000, 16'h000D, 0, 1, 0, 0, 1, 1);  // read while empty, q holds
    add(0, 1, 1, 16'h0011, 16'h000D, 1, 0, 0, 0, 1, 1);  // write proceeds, read ignored
    add(0, 1, 0, 16'h0022, 16'h000D, 2, 0, 0, 0, 1, 1);
    mid = n_vecs;
    // after the 10-cycle wr+rd run the FIFO holds 0x38,0x39 and q=0x37
    add(0, 1, 0, 16'h0040, 16'h0037, 3, 0, 0, 1, 1, 1);
    add(0, 1, 0, 16'h0041, 16'h0037, 4, 0, 1, 1, 1, 1);
    add(0, 1, 1, 16'h0042, 16'h0038, 3, 0, 0, 1, 1, 1);  // full: read taken, write dropped
    add(0, 0, 1, 16'h0000, 16'h0039, 2, 0, 0, 0, 1, 1);
    add(0, 0, 1, 16'h0000, 16'h0040, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 16'h0000, 16'h0041, 0, 1, 0, 0, 1, 1);  // 0x42 never stored
    add(0, 1, 0, 16'h0050, 16'h0041, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 16'h0051, 16'h0041, 2, 0, 0, 0, 1, 1);
    add(0, 1, 0, 16'h0052, 16'h0041, 3, 0, 0, 1, 1, 1);
    add(1, 1, 0, 16'h0053, 16'h0000, 0, 1, 0, 0, 0, 0);  // sclr beats wrreq
    add(0, 1, 0, 16'h0060, 16'h0000, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h0060, 0, 1, 0, 0, 0, 0);  // new data only

    repeat (2) @(posedge clock);
    #1;
    run_vecs(0, mid);

    // simultaneous write+read at usedw=2: order preserved across pointer wraps
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] d_in;
      logic [W-1:0] d_exp;
      d_in = W'(16'h0030 + k);
      exp_q.push_back(d_in);
      d_exp = exp_q.pop_front();
      step(1'b0, 1'b1, 1'b1, d_in);
`ifndef AFU_RFIFO_SHOWAHEAD_EN
      check($sformatf("wrap%0d q", k), 32'(q), 32'(d_exp));
`endif
      check($sformatf("wrap%0d usedw", k), 32'(usedw), 32'd2);
    end
    check("wrap sb depth", 32'(exp_q.size()), 32'd2);

    run_vecs(mid, n_vecs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
